cpu_sequencer: RTL

Multi-cycle fetch/decode/execute controller for the accumulator CPU. It owns the program counter and the instruction register, and runs the instruction-memory request/acknowledge handshake. It consumes the instruction decoder's control flags and issues single-cycle write strobes to the accumulator and register file. Sits between instruction memory, the instruction decoder (fed from `ir`) and the datapath.

---
 rtl/cpu_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the
// accumulator CPU. Owns pc and ir, runs the instruction-memory handshake and
// issues single-cycle write strobes to the datapath from the decoder flags.
//
// Fetch handshake: imem_req is a registered request that rises on the cycle
// after FETCH is entered and stays high until the word is accepted.
// A word transfers on a rising clk edge where imem_req and imem_ack are both
// high. imem_ack while imem_req is low carries no data and is ignored.
module cpu_sequencer #(
  parameter int CNTR_WIDTH    = 8,
  parameter int COMBINED_DATA = 24,
  parameter int TIMEOUT       = 15,
  parameter int ICNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     halt_req,
  output logic                     imem_req,
  output logic [CNTR_WIDTH-1:0]    imem_addr,
  input  logic                     imem_ack,
  input  logic [COMBINED_DATA-1:0] imem_data,
  output logic [COMBINED_DATA-1:0] ir,
  input  logic                     dec_rst_f,
  input  logic                     dec_jmp,
  input  logic                     dec_load,
  input  logic                     dec_store,
  output logic                     acc_we,
  output logic                     reg_we,
  output logic                     soft_rst,
  output logic [CNTR_WIDTH-1:0]    pc,
  output logic                     busy,
  output logic                     fault,
  output logic [ICNT_WIDTH-1:0]    instr_cnt,
  output logic [2:0]               dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]               state_q, state_d;
  logic [CNTR_WIDTH-1:0]    pc_q, pc_d;
  logic [COMBINED_DATA-1:0] ir_q, ir_d;
  logic [ICNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     req_q, req_d;
  logic                     acc_we_c, reg_we_c, soft_rst_c;

  // Next-state, datapath-register and strobe logic for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    req_d      = 1'b0;
    acc_we_c   = 1'b0;
    reg_we_c   = 1'b0;
    soft_rst_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (req_q && imem_ack) begin
          ir_d    = imem_data;
          tmo_d   = '0;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          // Request is withdrawn on the way into FAULT.
          tmo_d   = tmo_q + 1'b1;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
          req_d = 1'b1;
        end
      end
      S_DECODE: begin
        // Dead cycle so the decoder flags settle from the new ir.
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!dec_rst_f) begin
          soft_rst_c = 1'b1;
          pc_d       = '0;
        end else if (dec_jmp) begin
          pc_d = ir_q[CNTR_WIDTH-1:0];
        end else if (dec_store) begin
          reg_we_c = 1'b1;
          pc_d     = pc_q + 1'b1;
        end else if (dec_load) begin
          acc_we_c = 1'b1;
          pc_d     = pc_q + 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
        cnt_d   = cnt_q + 1'b1;
        state_d = halt_req ? S_IDLE : S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign instr_cnt = cnt_q;
  assign acc_we    = acc_we_c;
  assign reg_we    = reg_we_c;
  assign soft_rst  = soft_rst_c;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign fault     = (state_q == S_FAULT);
  assign dbg_state = state_q;

endmodule
